// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : Shared constants and types for the SHA-256 header hashing
//               subsystem. Holds the FIPS 180-4 initial hash words and round
//               constants (consumed by sha256_640), the nonce scheduler state
//               encoding and the job result codes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    // Initial hash value H(0) = {h0..h7}
    localparam logic [31:0] SHA256_H [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Round constants K[0..63]
    localparam logic [31:0] SHA256_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Scheduler state encoding
    typedef logic [2:0] sched_state_t;
    localparam sched_state_t ST_IDLE   = 3'd0;
    localparam sched_state_t ST_START  = 3'd1;
    localparam sched_state_t ST_WAIT   = 3'd2;
    localparam sched_state_t ST_CHECK  = 3'd3;
    localparam sched_state_t ST_REPORT = 3'd4;

    // Job result codes
    typedef enum logic [1:0] {
        RES_FOUND     = 2'd0,
        RES_EXHAUSTED = 2'd1,
        RES_ABORTED   = 2'd2,
        RES_TIMEOUT   = 2'd3
    } result_code_e;

endpackage
`default_nettype wire

// File: rtl/sha256_target_cmp.sv
`default_nettype none
// ============================================================================
// Module      : sha256_target_cmp
// Description : 256-bit unsigned "hash <= target" comparator. The compare is
//               evaluated on the live core hash in the cycle hash_done arrives
//               and registered, so the scheduler's CHECK state reads a flop
//               instead of a 256-bit carry chain.
// Ports       : clk            in   system clock
//               n_rst          in   asynchronous active-low reset
//               capture        in   register a new compare result this cycle
//               hash           in   [255:0] candidate hash, bit 255 = MSB
//               target         in   [255:0] target threshold
//               hash_le_target out  registered (hash <= target)
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_target_cmp (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         capture,
    input  logic [255:0] hash,
    input  logic [255:0] target,
    output logic         hash_le_target
);

    logic le_d;
    logic le_q;

    always_comb begin
        le_d = le_q;
        if (capture) begin
            le_d = (hash <= target);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            le_q <= 1'b0;
        end else begin
            le_q <= le_d;
        end
    end

    assign hash_le_target = le_q;

endmodule
`default_nettype wire

// File: rtl/sha256_nonce_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sha256_nonce_scheduler
// Description : Job controller for a single sha256_640 core. Accepts an
//               80-byte header job with an inclusive (wrapping) nonce range
//               and a 256-bit target, fires the core once per nonce and
//               returns one result per job: FOUND / EXHAUSTED / ABORTED /
//               TIMEOUT.
// Ports       : clk, n_rst                 clock, async active-low reset
//               job_valid/job_ready        job handshake (ready only in IDLE)
//               header, nonce_start,
//               nonce_end, target          job payload
//               abort                      stop the job at the next safe point
//               sha_enable, sha_data       start pulse and block to the core
//               sha_hash, sha_hash_done    core result
//               result_valid/result_ready  result handshake
//               result_code/nonce/hash     result payload
//               busy                       high outside IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_nonce_scheduler
    import sha256_pkg::*;
#(
    parameter int NONCE_LSB      = 0,
    parameter int TIMEOUT_CYCLES = 192
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [639:0] header,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    input  logic         abort,
    output logic         sha_enable,
    output logic [639:0] sha_data,
    input  logic [255:0] sha_hash,
    input  logic         sha_hash_done,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [1:0]   result_code,
    output logic [31:0]  result_nonce,
    output logic [255:0] result_hash,
    output logic         busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Last WAIT cycle in which hash_done is still accepted: the core gets
    // TIMEOUT_CYCLES cycles after the enable cycle to answer.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    sched_state_t  state_q,      state_d;
    logic [639:0]  header_q,     header_d;
    logic [255:0]  target_q,     target_d;
    logic [31:0]   nonce_q,      nonce_d;
    logic [31:0]   nonce_end_q,  nonce_end_d;
    logic [255:0]  hash_q,       hash_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic          abort_pend_q, abort_pend_d;
    logic [1:0]    res_code_q,   res_code_d;
    logic [31:0]   res_nonce_q,  res_nonce_d;
    logic [255:0]  res_hash_q,   res_hash_d;

    logic          hash_le_target;
    logic          cmp_capture;

    // Compare the live core hash as it arrives; the result is ready in CHECK.
    assign cmp_capture = (state_q == ST_WAIT) && sha_hash_done;

    sha256_target_cmp u_target_cmp (
        .clk            (clk),
        .n_rst          (n_rst),
        .capture        (cmp_capture),
        .hash           (sha_hash),
        .target         (target_q),
        .hash_le_target (hash_le_target)
    );

    always_comb begin
        state_d      = state_q;
        header_d     = header_q;
        target_d     = target_q;
        nonce_d      = nonce_q;
        nonce_end_d  = nonce_end_q;
        hash_d       = hash_q;
        cnt_d        = cnt_q;
        abort_pend_d = abort_pend_q;
        res_code_d   = res_code_q;
        res_nonce_d  = res_nonce_q;
        res_hash_d   = res_hash_q;

        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (job_valid) begin
                    header_d    = header;
                    target_d    = target;
                    nonce_end_d = nonce_end;
                    nonce_d     = nonce_start;
                    state_d     = ST_START;
                end
            end

            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An abort seen mid-hash is remembered and acted on in CHECK,
                // so the core always finishes the block it was given.
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (sha_hash_done) begin
                    hash_d  = sha_hash;
                    state_d = ST_CHECK;
                end else if (cnt_q == CNT_LAST) begin
                    res_code_d  = RES_TIMEOUT;
                    res_nonce_d = nonce_q;
                    res_hash_d  = '0;
                    state_d     = ST_REPORT;
                end
            end

            ST_CHECK: begin
                res_nonce_d = nonce_q;
                res_hash_d  = hash_q;
                if (hash_le_target) begin
                    res_code_d = RES_FOUND;
                    state_d    = ST_REPORT;
                end else if (nonce_q == nonce_end_q) begin
                    res_code_d = RES_EXHAUSTED;
                    state_d    = ST_REPORT;
                end else if (abort || abort_pend_q) begin
                    res_code_d = RES_ABORTED;
                    state_d    = ST_REPORT;
                end else begin
                    // Result fields are only observed in REPORT; restore them
                    // so they do not toggle while the job is still running.
                    res_nonce_d = res_nonce_q;
                    res_hash_d  = res_hash_q;
                    nonce_d     = nonce_q + 32'd1;
                    state_d     = ST_START;
                end
            end

            ST_REPORT: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            header_q     <= '0;
            target_q     <= '0;
            nonce_q      <= '0;
            nonce_end_q  <= '0;
            hash_q       <= '0;
            cnt_q        <= '0;
            abort_pend_q <= 1'b0;
            res_code_q   <= '0;
            res_nonce_q  <= '0;
            res_hash_q   <= '0;
        end else begin
            state_q      <= state_d;
            header_q     <= header_d;
            target_q     <= target_d;
            nonce_q      <= nonce_d;
            nonce_end_q  <= nonce_end_d;
            hash_q       <= hash_d;
            cnt_q        <= cnt_d;
            abort_pend_q <= abort_pend_d;
            res_code_q   <= res_code_d;
            res_nonce_q  <= res_nonce_d;
            res_hash_q   <= res_hash_d;
        end
    end

    // The core block is the latched header with the current nonce spliced in;
    // both sources are registers, so it is stable from START through WAIT.
    always_comb begin
        sha_data                    = header_q;
        sha_data[NONCE_LSB +: 32]   = nonce_q;
    end

    assign sha_enable   = (state_q == ST_START);
    assign job_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = (state_q == ST_REPORT);
    assign result_code  = res_code_q;
    assign result_nonce = res_nonce_q;
    assign result_hash  = res_hash_q;

endmodule
`default_nettype wire
